kfps2kb_event_decoder: RTL and testbench

//   Consumer stage placed directly after the PS/2 keyboard controller.
//   - Takes the controller's irq/keycode holding register and acknowledges each byte with clear_keycode.
//   - Folds scan-code-set-2 prefix bytes (E0, F0, E1 pause sequence) into single key events:

---
 rtl/kfps2kb_event_decoder.sv | 191 +++++++++++++++++++
 tb/tb_kfps2kb_event_decoder.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kfps2kb_event_decoder.sv
// PS/2 set-2 scan byte consumer: folds prefix bytes into key events
// and queues them for the host on a show-ahead valid/ready FIFO.
module kfps2kb_event_decoder #(
   parameter  int FIFO_DEPTH = 8,
   localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          irq,
   input  logic [7:0]    keycode,
   output logic          clear_keycode,
   output logic          event_valid,
   input  logic          event_ready,
   output logic [7:0]    event_code,
   output logic          event_break,
   output logic          event_extended,
   output logic          event_error,
   output logic [CW-1:0] fifo_count,
   output logic          overflow,
   input  logic          clear_overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [7:0] K_E0    = 8'hE0;
   localparam logic [7:0] K_F0    = 8'hF0;
   localparam logic [7:0] K_E1    = 8'hE1;
   localparam logic [7:0] K_ERR   = 8'hFF;
   localparam logic [7:0] K_PAUSE = 8'h77;

   typedef enum logic [2:0] {
      S_IDLE,
      S_E0,
      S_F0,
      S_E0F0,
      S_PAUSE
   } state_t;

   typedef struct packed {
      logic       err;
      logic       brk;
      logic       ext;
      logic [7:0] code;
   } event_t;

   state_t        state, nxt_state;
   logic [2:0]    cnt, nxt_cnt;
   logic [7:0]    byte_q;
   logic          dec_push;
   event_t        dec_ev;
   event_t        head;
   event_t        mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic          full, pop, push, drop;

   // clear_keycode doubles as "byte_q holds a fresh byte this cycle"
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clear_keycode <= 1'b0;
         byte_q        <= '0;
      end else begin
         clear_keycode <= irq & ~clear_keycode;
         if (irq & ~clear_keycode)
            byte_q <= keycode;
      end
   end

   always_comb begin
      dec_push   = 1'b0;
      dec_ev     = '0;
      dec_ev.code = byte_q;
      nxt_state  = state;
      nxt_cnt    = cnt;
      if (clear_keycode) begin
         if (byte_q == K_ERR) begin
            dec_push   = 1'b1;
            dec_ev.err = 1'b1;
            nxt_state  = S_IDLE;
            nxt_cnt    = '0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  unique case (1'b1)
                     byte_q == K_E0: nxt_state = S_E0;
                     byte_q == K_F0: nxt_state = S_F0;
                     byte_q == K_E1: begin
                        nxt_state = S_PAUSE;
                        nxt_cnt   = 3'd7;
                     end
                     default: dec_push = 1'b1;
                  endcase
               end
               S_E0: begin
                  unique case (1'b1)
                     byte_q == K_F0: nxt_state = S_E0F0;
                     byte_q == K_E0: nxt_state = S_E0;
                     default: begin
                        dec_push   = 1'b1;
                        dec_ev.ext = 1'b1;
                        nxt_state  = S_IDLE;
                     end
                  endcase
               end
               S_F0: begin
                  dec_push   = 1'b1;
                  dec_ev.brk = 1'b1;
                  nxt_state  = S_IDLE;
               end
               S_E0F0: begin
                  dec_push   = 1'b1;
                  dec_ev.brk = 1'b1;
                  dec_ev.ext = 1'b1;
                  nxt_state  = S_IDLE;
               end
               S_PAUSE: begin
                  // the seven trailing pause bytes collapse to one event
                  if (cnt <= 3'd1) begin
                     dec_push    = 1'b1;
                     dec_ev.ext  = 1'b1;
                     dec_ev.code = K_PAUSE;
                     nxt_state   = S_IDLE;
                     nxt_cnt     = '0;
                  end else begin
                     nxt_cnt = cnt - 3'd1;
                  end
               end
               default: begin
                  nxt_state = S_IDLE;
                  nxt_cnt   = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
      end
   end

   assign full        = fifo_count == CW'(FIFO_DEPTH);
   assign event_valid = fifo_count != '0;
   assign pop         = event_valid & event_ready;
   assign push        = dec_push & (~full | pop);
   assign drop        = dec_push & full & ~pop;

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= dec_ev;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         overflow <= 1'b0;
      else if (clear_overflow)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
   end

   // storage is not reset, so the head is masked while empty
   assign head           = event_valid ? mem[rd_ptr] : '0;
   assign event_code     = head.code;
   assign event_break    = head.brk;
   assign event_extended = head.ext;
   assign event_error    = head.err;

endmodule

// File: tb/tb_kfps2kb_event_decoder.sv
// Bench for kfps2kb_event_decoder: directed scenarios plus random byte
// streams checked against a prefix-flag reference decoder and queue.
module tb_kfps2kb_event_decoder;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          irq = 1'b0;
   logic [7:0]    keycode = 8'h00;
   logic          clear_keycode;
   logic          event_valid;
   logic          event_ready = 1'b0;
   logic [7:0]    event_code;
   logic          event_break;
   logic          event_extended;
   logic          event_error;
   logic [CW-1:0] fifo_count;
   logic          overflow;
   logic          clear_overflow = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [10:0] mq[$];
   bit          m_ovf = 1'b0;
   bit          m_ext = 1'b0;
   bit          m_brk = 1'b0;
   int          m_pause = 0;

   kfps2kb_event_decoder #(.FIFO_DEPTH(DEPTH)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .irq(irq),
      .keycode(keycode),
      .clear_keycode(clear_keycode),
      .event_valid(event_valid),
      .event_ready(event_ready),
      .event_code(event_code),
      .event_break(event_break),
      .event_extended(event_extended),
      .event_error(event_error),
      .fifo_count(fifo_count),
      .overflow(overflow),
      .clear_overflow(clear_overflow)
   );

   always #5 clock = ~clock;

   function automatic logic [10:0] head();
      return {event_error, event_break, event_extended, event_code};
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_ovf = 1'b0;
      m_ext = 1'b0;
      m_brk = 1'b0;
      m_pause = 0;
   endfunction

   // reference: prefix flags accumulate until a final byte closes the key
   function automatic void model_byte(logic [7:0] b, bit pop, bit clr);
      bit          has = 1'b0;
      logic [10:0] ev = '0;
      if (b == 8'hFF) begin
         has = 1'b1;
         ev = {3'b100, 8'hFF};
         m_ext = 1'b0;
         m_brk = 1'b0;
         m_pause = 0;
      end else if (m_pause > 0) begin
         m_pause--;
         if (m_pause == 0) begin
            has = 1'b1;
            ev = {3'b001, 8'h77};
         end
      end else if (m_brk) begin
         has = 1'b1;
         ev = {1'b0, 1'b1, m_ext, b};
         m_brk = 1'b0;
         m_ext = 1'b0;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hE1 && !m_ext) begin
         m_pause = 7;
      end else begin
         has = 1'b1;
         ev = {2'b00, m_ext, b};
         m_ext = 1'b0;
      end
      if (pop && mq.size() > 0)
         void'(mq.pop_front());
      if (has) begin
         if (mq.size() < DEPTH)
            mq.push_back(ev);
         else
            m_ovf = 1'b1;
      end
      if (clr)
         m_ovf = 1'b0;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit pop = 1'b0,
                            input bit clr = 1'b0);
      int n;
      @(negedge clock);
      irq = 1'b1;
      keycode = b;
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (!clear_keycode && n < 4);
      checks++;
      if (clear_keycode !== 1'b1) begin
         errors++;
         $display("FAIL ack_rise byte %h: clear_keycode=%b want 1", b, clear_keycode);
      end
      event_ready = pop;
      clear_overflow = clr;
      model_byte(b, pop, clr);
      @(negedge clock);
      irq = 1'b0;
      @(posedge clock);
      #1;
      event_ready = 1'b0;
      clear_overflow = 1'b0;
      checks++;
      if (clear_keycode !== 1'b0) begin
         errors++;
         $display("FAIL ack_width byte %h: clear_keycode=%b want 0", b, clear_keycode);
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = mq.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         checks++;
         if (event_valid !== 1'b1 || head() !== mq[0]) begin
            errors++;
            $display("FAIL %s pop%0d: valid=%b ev=%h want valid=1 ev=%h",
                     name, i, event_valid, head(), mq[0]);
         end
         checks++;
         if (fifo_count !== CW'(mq.size())) begin
            errors++;
            $display("FAIL %s count%0d: got %0d want %0d", name, i,
                     fifo_count, mq.size());
         end
         void'(mq.pop_front());
         event_ready = 1'b1;
         @(posedge clock);
         #1;
         event_ready = 1'b0;
      end
      @(negedge clock);
      checks++;
      if (event_valid !== 1'b0 || fifo_count !== '0) begin
         errors++;
         $display("FAIL %s empty: valid=%b count=%0d want 0/0", name,
                  event_valid, fifo_count);
      end
   endtask

   task automatic test_reset();
      irq = 1'b1;
      keycode = 8'h1C;
      repeat (3) @(negedge clock);
      checks++;
      if ({clear_keycode, event_valid, event_code, event_break, event_extended,
           event_error, fifo_count, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ack=%b valid=%b ev=%h count=%0d ovf=%b want all 0",
                  clear_keycode, event_valid, head(), fifo_count, overflow);
      end
      irq = 1'b0;
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_make();
      send_byte(8'h1C);
      checks++;
      if (event_valid !== 1'b1 || fifo_count !== CW'(1) || head() !== 11'h01C) begin
         errors++;
         $display("FAIL make: valid=%b count=%0d ev=%h want 1/1/01c",
                  event_valid, fifo_count, head());
      end
      drain("make");
   endtask

   task automatic test_break();
      send_byte(8'hF0);
      checks++;
      if (fifo_count !== '0) begin
         errors++;
         $display("FAIL break_prefix: count=%0d want 0", fifo_count);
      end
      send_byte(8'h1C);
      checks++;
      if (fifo_count !== CW'(1) || head() !== 11'h21C) begin
         errors++;
         $display("FAIL break: count=%0d ev=%h want 1/21c", fifo_count, head());
      end
      drain("break");
   endtask

   task automatic test_ext_break();
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      send_byte(8'h1C);
      checks++;
      if (fifo_count !== CW'(2) || head() !== 11'h375) begin
         errors++;
         $display("FAIL ext_break: count=%0d ev=%h want 2/375", fifo_count, head());
      end
      drain("ext_break");
   endtask

   task automatic test_pause();
      logic [7:0] seq [8];
      seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      foreach (seq[i])
         send_byte(seq[i]);
      checks++;
      if (fifo_count !== CW'(1) || head() !== 11'h177) begin
         errors++;
         $display("FAIL pause: count=%0d ev=%h want 1/177", fifo_count, head());
      end
      drain("pause");
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 9; i++)
         send_byte(8'(i));
      checks++;
      if (fifo_count !== CW'(DEPTH) || overflow !== 1'b1 || head() !== 11'h001) begin
         errors++;
         $display("FAIL overflow: count=%0d ovf=%b ev=%h want 8/1/001",
                  fifo_count, overflow, head());
      end
      drain("overflow");
      @(negedge clock);
      clear_overflow = 1'b1;
      @(posedge clock);
      #1;
      clear_overflow = 1'b0;
      m_ovf = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL clear_overflow: ovf=%b want 0", overflow);
      end
   endtask

   task automatic test_full_boundary();
      for (int i = 0; i < DEPTH; i++)
         send_byte(8'h10 + 8'(i));
      send_byte(8'h18, 1'b1, 1'b0);
      checks++;
      if (fifo_count !== CW'(DEPTH) || overflow !== 1'b0 || head() !== 11'h011) begin
         errors++;
         $display("FAIL full_push_pop: count=%0d ovf=%b ev=%h want 8/0/011",
                  fifo_count, overflow, head());
      end
      send_byte(8'h19, 1'b0, 1'b1);
      checks++;
      if (fifo_count !== CW'(DEPTH) || overflow !== 1'b0) begin
         errors++;
         $display("FAIL clear_beats_drop: count=%0d ovf=%b want 8/0",
                  fifo_count, overflow);
      end
      drain("full_boundary");
   endtask

   task automatic test_error();
      send_byte(8'hE0);
      send_byte(8'hFF);
      send_byte(8'h1C);
      checks++;
      if (fifo_count !== CW'(2) || head() !== 11'h4FF) begin
         errors++;
         $display("FAIL error_event: count=%0d ev=%h want 2/4ff", fifo_count, head());
      end
      drain("error");
   endtask

   task automatic test_reset_mid();
      send_byte(8'h1C);
      send_byte(8'hE0);
      send_byte(8'hF0);
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({clear_keycode, event_valid, event_code, event_break, event_extended,
           event_error, fifo_count, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_mid: valid=%b ev=%h count=%0d ovf=%b want all 0",
                  event_valid, head(), fifo_count, overflow);
      end
      model_reset();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      send_byte(8'h1C);
      checks++;
      if (fifo_count !== CW'(1) || head() !== 11'h01C) begin
         errors++;
         $display("FAIL after_reset: count=%0d ev=%h want 1/01c", fifo_count, head());
      end
      drain("reset_mid");
   endtask

   task automatic test_random();
      logic [7:0] pool [10];
      logic [7:0] b;
      int         k;
      pool = '{8'hE0, 8'hF0, 8'hE1, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'h1C,
               8'h14, 8'h77};
      for (int i = 0; i < 300; i++) begin
         k = $urandom_range(0, 12);
         b = (k < 10) ? pool[k] : 8'($urandom_range(0, 255));
         send_byte(b);
         if ($urandom_range(0, 7) == 0) begin
            checks++;
            if (overflow !== m_ovf) begin
               errors++;
               $display("FAIL random_ovf: ovf=%b want %b", overflow, m_ovf);
            end
            drain("random");
         end
      end
      checks++;
      if (overflow !== m_ovf) begin
         errors++;
         $display("FAIL random_ovf_end: ovf=%b want %b", overflow, m_ovf);
      end
      drain("random_end");
   endtask

   initial begin
      test_reset();
      test_make();
      test_break();
      test_ext_break();
      test_pause();
      test_overflow();
      test_full_boundary();
      test_error();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
